uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Parametrised single-clock UART receiver with an integrated first-word-fall-through receive FIFO. It is the next-generation replacement for the byte-only receive path. It adds configurable data width, optional parity, configurable FIFO depth, an occupancy count and sticky error reporting (framing, parity, overrun). It sits between the board rxd pin and the core's I/O load path.

Parameters:
CLK_PER_HALF_BIT, 5208, clk cycles per half bit period; must be >= 2.
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
FIFO_DEPTH, 16, receive FIFO entries; must be a power of two, >= 2.

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
rxd  in  1  serial input, asynchronous to clk, idle high
rd_en  in  1  pop request; ignored when empty=1
dout  out  DATA_BITS  FIFO head; valid whenever empty=0 (FWFT)
empty  out  1  FIFO holds 0 entries
full  out  1  FIFO holds FIFO_DEPTH entries
count  out  $clog2(FIFO_DEPTH)+1  current occupancy
ferr  out  1  sticky: stop bit sampled low
perr  out  1  sticky: parity mismatch
overrun  out  1  sticky: frame completed while FIFO full
err_clr  in  1  one-cycle pulse; clears ferr, perr and overrun

Behaviour:
- Reset: state IDLE_WAIT; synchroniser flops = 1; counters = 0; FIFO pointers = 0; dout = 0; empty=1, full=0, count=0; ferr=perr=overrun=0.
- rxd passes through a 2-flop synchroniser. All references to "line" below mean the synchronised value.
- FSM states:
  - IDLE_WAIT: stay until the line is high. Entered after reset and after a framing error, so receive never starts mid-frame.
  - IDLE: on line==0, go to START and load the bit counter with CLK_PER_HALF_BIT-1.
  - START: when the counter expires, sample the line. If 1 (glitch), go to IDLE with nothing recorded. If 0, go to DATA with counter = 2*CLK_PER_HALF_BIT-1.
  - DATA: sample at each expiry; shift in LSB first. After DATA_BITS samples, go to PARITY if PARITY!=0, else to STOP.
  - PARITY: sample one bit. Odd: data XOR parity must be 1. Even: data XOR parity must be 0. Record the mismatch and go to STOP.
  - STOP: sample the stop bit.
    - Stop = 0: set ferr, discard the frame, go to IDLE_WAIT.
    - Stop = 1 with parity mismatch: set perr, discard the frame, go to IDLE.
    - Stop = 1 otherwise: push the frame in the stop-sample cycle, go to IDLE.
- Push rules: a push while full=1 with no simultaneous pop drops the frame and sets overrun. A push and a pop in the same cycle while full=1 both succeed; count is unchanged.
- FIFO timing:
  - A push into an empty FIFO shows on dout, with empty=0, on the next clk edge (1-cycle latency from the stop sample).
  - A pop advances the head on the next edge.
  - Simultaneous push and pop when count==1 leaves count=1 with dout = the new word.
  - rd_en while empty=1 has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - count, full and empty are registered and consistent in every cycle.
- Error flags: sticky until err_clr. If a set and err_clr occur in the same cycle, set wins. Flags never block reception.
- Reset mid-frame: the partial frame is lost, the FIFO is emptied, flags are cleared, and the block re-arms via IDLE_WAIT.
- Frame period = (2 + DATA_BITS + (PARITY!=0)) * 2*CLK_PER_HALF_BIT cycles. Back-to-back frames must be received with no idle gap between stop bit and next start bit.

Test Plan:
1. CLK_PER_HALF_BIT=4, DATA_BITS=8, PARITY=0: send 0xA5 then 0x3C back-to-back -> empty falls 1 cycle after the first stop sample with dout=0xA5; count reaches 2; two rd_en pulses -> dout 0x3C then empty=1; no flags set.
2. PARITY=2: send 0x07 with parity bit 1 -> pushed, perr=0. Send 0x07 with parity bit 0 -> not pushed, count unchanged, perr=1. err_clr pulse -> perr=0.
3. Send 0x55 with stop bit driven 0, then line held low 40 cycles, then high -> ferr=1, nothing pushed. FSM stays in IDLE_WAIT until the line is high; a following 0x12 frame is received correctly.
4. FIFO_DEPTH=4: send 5 frames 0x01..0x05 with no reads -> full=1, count=4, overrun=1, dout=0x01. Pop all -> 0x01..0x04 in order, empty=1.
5. With full=1, assert rd_en in the stop-sample cycle of frame 0x66 -> count stays 4, overrun stays 0, 0x66 is read last.
6. 3-cycle low glitch on rxd (less than CLK_PER_HALF_BIT) -> no push, no flags. Assert rstn=0 mid-frame with 2 entries queued -> empty=1, count=0, all flags 0; next frame 0x9C is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//
// Single-clock UART receiver feeding a first-word-fall-through receive FIFO.
// The serial input is synchronised and then sampled at mid-bit by a half-bit
// timed FSM. Payload width, optional parity and FIFO depth are parameters.
// Framing, parity and overrun errors are reported as sticky flags.
//
// Parameters:
//   CLK_PER_HALF_BIT  clk cycles per half bit period (>= 2)
//   DATA_BITS         payload bits per frame (5..9)
//   PARITY            0 = none, 1 = odd, 2 = even
//   FIFO_DEPTH        receive FIFO entries (power of two, >= 2)
//
// Ports:
//   clk      in   system clock
//   rstn     in   asynchronous active-low reset
//   rxd      in   serial input, asynchronous to clk, idle high
//   rd_en    in   pop request; ignored while empty
//   dout     out  FIFO head, valid whenever empty = 0
//   empty    out  FIFO holds no entries
//   full     out  FIFO holds FIFO_DEPTH entries
//   count    out  current occupancy
//   ferr     out  sticky: stop bit sampled low
//   perr     out  sticky: parity mismatch
//   overrun  out  sticky: frame completed while FIFO full
//   err_clr  in   one-cycle pulse clearing ferr, perr and overrun
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int DATA_BITS        = 8,
  parameter int PARITY           = 0,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [DATA_BITS-1:0]          dout,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          ferr,
  output logic                          perr,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int TIMER_W = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int IDX_W   = $clog2(DATA_BITS);

  localparam logic [TIMER_W-1:0] HALF_LOAD = TIMER_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [TIMER_W-1:0] FULL_LOAD = TIMER_W'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic               HAS_PAR   = (PARITY != 0);
  localparam logic               ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE_WAIT,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser (reset to the idle-high level)
  // ---------------------------------------------------------------------------
  logic meta_q, meta_d;
  logic line_q, line_d;

  always_comb begin
    meta_d = rxd;
    line_d = meta_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      line_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      line_q <= line_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;

  logic tick;
  logic frame_ok;
  logic ferr_set;
  logic perr_set;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    frame_ok  = 1'b0;
    ferr_set  = 1'b0;
    perr_set  = 1'b0;
    tick      = (timer_q == '0);

    // The bit timer free-runs down to zero in every in-frame state; each
    // expiry is one mid-bit sample point, after which it is reloaded.
    if (state_q != S_IDLE_WAIT && state_q != S_IDLE && !tick) begin
      timer_d = timer_q - 1'b1;
    end

    case (state_q)
      S_IDLE_WAIT: begin
        // Only re-arm once the line is seen idle, so a stuck-low line or
        // the tail of a broken frame never looks like a start bit.
        if (line_q) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (!line_q) begin
          state_d = S_START;
          timer_d = HALF_LOAD;
        end
      end

      S_START: begin
        if (tick) begin
          if (line_q) begin
            // Low pulse shorter than half a bit: treat as noise.
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            timer_d   = FULL_LOAD;
            bit_idx_d = '0;
            par_bad_d = 1'b0;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          shift_d = {line_q, shift_q[DATA_BITS-1:1]};
          timer_d = FULL_LOAD;
          if (bit_idx_q == LAST_IDX) begin
            state_d = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (tick) begin
          timer_d   = FULL_LOAD;
          // XOR of payload and parity bit is 1 for odd, 0 for even.
          par_bad_d = (^shift_q) ^ line_q ^ ODD_PAR;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (tick) begin
          if (!line_q) begin
            ferr_set = 1'b1;
            state_d  = S_IDLE_WAIT;
          end else if (par_bad_q) begin
            perr_set = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_ok = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE_WAIT;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FWFT receive FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     rd_next_ptr;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;

  logic pop;
  logic push_ok;
  logic overrun_set;

  always_comb begin
    pop         = rd_en & ~empty_q;
    // When full, a same-cycle pop frees the slot the new word lands in.
    push_ok     = frame_ok & (~full_q | pop);
    overrun_set = frame_ok & full_q & ~pop;
    rd_next_ptr = rd_ptr_q + 1'b1;

    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_next_ptr : rd_ptr_q;

    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);

    // dout is a registered copy of the head entry. On a pop the next head
    // is read from memory; when the FIFO holds at most one surviving word
    // the incoming frame bypasses memory and becomes the head directly.
    dout_d = dout_q;
    if (pop && (count_q > CNT_ONE)) begin
      dout_d = fifo_mem[rd_next_ptr];
    end
    if (push_ok && ((count_q == '0) || ((count_q == CNT_ONE) && pop))) begin
      dout_d = shift_q;
    end
  end

  // Storage has no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      dout_q   <= dout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags (a set in the same cycle as err_clr wins)
  // ---------------------------------------------------------------------------
  logic ferr_q, ferr_d;
  logic perr_q, perr_d;
  logic overrun_q, overrun_d;

  always_comb begin
    ferr_d    = ferr_set    | (ferr_q    & ~err_clr);
    perr_d    = perr_set    | (perr_q    & ~err_clr);
    overrun_d = overrun_set | (overrun_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      overrun_q <= overrun_d;
    end
  end

  assign dout    = dout_q;
  assign empty   = empty_q;
  assign full    = full_q;
  assign count   = count_q;
  assign ferr    = ferr_q;
  assign perr    = perr_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Two receivers share clock and reset: dut0 without parity, dut1 with even
// parity, both with CLK_PER_HALF_BIT = 4 and a 4-entry FIFO. Stimulus pushes
// the words it expects to be received into per-DUT queues; a negedge monitor
// pops and compares whenever a read is accepted by the DUT.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int H       = 4;
  localparam int BIT_CYC = 2 * H;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       rxd0, rxd1;
  logic       rd0, rd1;
  logic       clr0, clr1;
  logic [7:0] dout0, dout1;
  logic       empty0, empty1, full0, full1;
  logic [2:0] count0, count1;
  logic       ferr0, perr0, overrun0;
  logic       ferr1, perr1, overrun1;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic [7:0] e0, e1;

  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)
  ) dut0 (
    .clk(clk), .rstn(rstn), .rxd(rxd0), .rd_en(rd0), .dout(dout0),
    .empty(empty0), .full(full0), .count(count0), .ferr(ferr0),
    .perr(perr0), .overrun(overrun0), .err_clr(clr0)
  );

  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(H), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)
  ) dut1 (
    .clk(clk), .rstn(rstn), .rxd(rxd1), .rd_en(rd1), .dout(dout1),
    .empty(empty1), .full(full1), .count(count1), .ferr(ferr1),
    .perr(perr1), .overrun(overrun1), .err_clr(clr1)
  );

  // Scoreboard monitor: every accepted pop is checked against the queue head.
  always @(negedge clk) begin
    if (rstn && rd0 && !empty0) begin
      total++;
      if (exp0.size() == 0) begin
        bad++;
        $display("FAIL pop0: got %02h required nothing (no word expected)", dout0);
      end else begin
        e0 = exp0.pop_front();
        if (dout0 !== e0) begin
          bad++;
          $display("FAIL pop0: got %02h required %02h", dout0, e0);
        end else begin
          $display("pop dut0 data=%02h", dout0);
        end
      end
    end
    if (rstn && rd1 && !empty1) begin
      total++;
      if (exp1.size() == 0) begin
        bad++;
        $display("FAIL pop1: got %02h required nothing (no word expected)", dout1);
      end else begin
        e1 = exp1.pop_front();
        if (dout1 !== e1) begin
          bad++;
          $display("FAIL pop1: got %02h required %02h", dout1, e1);
        end else begin
          $display("pop dut1 data=%02h", dout1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("check %s = %0h", name, act);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input int sel, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rxd0 = bits[i];
      else          rxd1 = bits[i];
      cyc(BIT_CYC);
    end
  endtask

  task automatic frame0(input logic [7:0] d, input logic stopb);
    drive_bits(0, {2'b00, stopb, d, 1'b0}, 10);
  endtask

  task automatic frame1(input logic [7:0] d, input logic parb);
    drive_bits(1, {1'b0, 1'b1, parb, d, 1'b0}, 11);
  endtask

  task automatic pop0(input int n);
    rd0 = 1'b1;
    cyc(n);
    rd0 = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    rxd0 = 1'b1; rxd1 = 1'b1;
    rd0  = 1'b0; rd1  = 1'b0;
    clr0 = 1'b0; clr1 = 1'b0;
    cyc(3);

    // Reset state
    chk("rst_empty0", empty0, 1);
    chk("rst_full0", full0, 0);
    chk("rst_count0", count0, 0);
    chk("rst_dout0", dout0, 8'h00);
    chk("rst_flags0", {ferr0, perr0, overrun0}, 0);
    chk("rst_state1", {empty1, full1, count1}, 5'b10000);
    chk("rst_flags1", {ferr1, perr1, overrun1}, 0);
    rstn = 1'b1;
    cyc(5);

    // 1: back-to-back frames, FWFT latency, ordered pops
    exp0.push_back(8'hA5);
    exp0.push_back(8'h3C);
    fork
      begin
        frame0(8'hA5, 1'b1);
        frame0(8'h3C, 1'b1);
      end
      begin
        cyc(78);                       // stop-sample cycle of first frame
        chk("t1_empty_at_stop", empty0, 1);
        cyc(1);
        chk("t1_empty_after", empty0, 0);
        chk("t1_dout_first", dout0, 8'hA5);
      end
    join
    cyc(4);
    chk("t1_count2", count0, 2);
    chk("t1_flags", {ferr0, perr0, overrun0}, 0);
    pop0(1);
    chk("t1_dout_second", dout0, 8'h3C);
    chk("t1_count1", count0, 1);
    pop0(1);
    chk("t1_empty_end", empty0, 1);

    // 2: even parity good / bad, err_clr
    exp1.push_back(8'h07);
    frame1(8'h07, 1'b1);
    cyc(2);
    chk("t2_count_good", count1, 1);
    chk("t2_perr_good", perr1, 0);
    frame1(8'h07, 1'b0);
    cyc(2);
    chk("t2_count_bad", count1, 1);
    chk("t2_perr_bad", perr1, 1);
    clr1 = 1'b1;
    cyc(1);
    clr1 = 1'b0;
    chk("t2_perr_clr", perr1, 0);
    rd1 = 1'b1;
    cyc(1);
    rd1 = 1'b0;
    chk("t2_empty", empty1, 1);

    // 3: framing error, line held low, recovery
    drive_bits(0, {2'b00, 1'b0, 8'h55, 1'b0}, 10);
    cyc(40);
    chk("t3_ferr", ferr0, 1);
    chk("t3_count_low", count0, 0);
    rxd0 = 1'b1;
    cyc(20);
    chk("t3_count_idle", count0, 0);
    clr0 = 1'b1;
    cyc(1);
    clr0 = 1'b0;
    chk("t3_ferr_clr", ferr0, 0);
    exp0.push_back(8'h12);
    frame0(8'h12, 1'b1);
    cyc(2);
    chk("t3_count_rx", count0, 1);
    pop0(1);
    chk("t3_empty", empty0, 1);

    // 4: fill and overrun
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp0.push_back(8'(i));
      frame0(8'(i), 1'b1);
    end
    cyc(2);
    chk("t4_full", full0, 1);
    chk("t4_count", count0, 4);
    chk("t4_overrun", overrun0, 1);
    chk("t4_dout", dout0, 8'h01);
    chk("t4_other_flags", {ferr0, perr0}, 0);
    pop0(4);
    chk("t4_empty", empty0, 1);
    chk("t4_count0", count0, 0);
    chk("t4_full_clr", full0, 0);

    // 5: push and pop together while full
    clr0 = 1'b1;
    cyc(1);
    clr0 = 1'b0;
    chk("t5_overrun_clr", overrun0, 0);
    for (int i = 0; i < 4; i++) begin
      exp0.push_back(8'h61 + 8'(i));
      frame0(8'h61 + 8'(i), 1'b1);
    end
    chk("t5_full_pre", full0, 1);
    exp0.push_back(8'h66);
    fork
      frame0(8'h66, 1'b1);
      begin
        cyc(78);
        rd0 = 1'b1;
        cyc(1);
        rd0 = 1'b0;
      end
    join
    cyc(1);
    chk("t5_count", count0, 4);
    chk("t5_full", full0, 1);
    chk("t5_overrun", overrun0, 0);
    chk("t5_dout", dout0, 8'h62);
    pop0(4);
    chk("t5_empty", empty0, 1);

    // 6a: short glitch is ignored
    rxd0 = 1'b0;
    cyc(3);
    rxd0 = 1'b1;
    cyc(40);
    chk("t6_glitch_count", count0, 0);
    chk("t6_glitch_flags", {ferr0, perr0, overrun0}, 0);

    // 6b: reset mid-frame with two entries queued and a flag set
    frame0(8'h11, 1'b1);
    frame0(8'h22, 1'b1);
    drive_bits(0, {2'b00, 1'b0, 8'h44, 1'b0}, 10);
    rxd0 = 1'b1;
    cyc(4);
    chk("t6_count_pre", count0, 2);
    chk("t6_ferr_pre", ferr0, 1);
    rxd0 = 1'b0;
    cyc(12);
    rstn = 1'b0;
    rxd0 = 1'b1;
    #1;
    chk("t6_rst_fifo", {empty0, full0, count0}, 5'b10000);
    chk("t6_rst_flags", {ferr0, perr0, overrun0}, 0);
    cyc(3);
    rstn = 1'b1;
    cyc(5);
    exp0.push_back(8'h9C);
    frame0(8'h9C, 1'b1);
    cyc(2);
    chk("t6_count_rx", count0, 1);
    chk("t6_dout_rx", dout0, 8'h9C);
    pop0(1);
    chk("t6_empty", empty0, 1);

    chk("left_in_queue0", exp0.size(), 0);
    chk("left_in_queue1", exp1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
